truth_table_sequencer: RTL and testbench

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

---
 rtl/truth_table_sequencer.sv | 111 +++++++++++
 tb/tb_truth_table_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: drives every input vector of a combinational block and checks y_in
// against EXPECTED. Optional macro TT_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module truth_table_sequencer #(
  parameter int N_IN = 3,
  parameter int SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0] EXPECTED = 8'h31
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            y_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   fail_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail_idx
);

  // state | meaning
  // IDLE  | waiting for start, vec_out parked at 0
  // DRIVE | vec_out = idx, waiting SETTLE cycles for the block to settle
  // CHECK | one cycle: compare y_in with EXPECTED[idx]
  // DONE  | one-cycle done pulse, pass registered
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [N_IN:0]   N_VEC       = (N_IN+1)'(1 << N_IN);
  localparam logic [N_IN-1:0] IDX_LAST    = '1;
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

  logic [1:0]      state;
  logic [N_IN-1:0] idx;
  logic [3:0]      settle_cnt;
  logic            mismatch;
  logic            sweep_end;
  logic [N_IN:0]   fail_count_nxt;

  always_comb begin
    // case inequality so an X/Z from the block under test counts as a failure
    mismatch = (y_in !== EXPECTED[idx]);
    fail_count_nxt = fail_count;
    if (mismatch && (fail_count != N_VEC))
      fail_count_nxt = fail_count + (N_IN+1)'(1);
`ifdef TT_STOP_ON_FAIL_EN
    sweep_end = (idx == IDX_LAST) || mismatch;
`else
    sweep_end = (idx == IDX_LAST);
`endif
  end

  assign busy    = (state == S_DRIVE) || (state == S_CHECK);
  assign done    = (state == S_DONE);
  assign vec_out = busy ? idx : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      idx            <= '0;
      settle_cnt     <= '0;
      fail_count     <= '0;
      fail_valid     <= 1'b0;
      first_fail_idx <= '0;
      pass           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state          <= S_DRIVE;
            idx            <= '0;
            settle_cnt     <= '0;
            fail_count     <= '0;
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
            pass           <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state      <= S_CHECK;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        S_CHECK: begin
          fail_count <= fail_count_nxt;
          if (mismatch && !fail_valid) begin
            fail_valid     <= 1'b1;
            first_fail_idx <= idx;
          end
          if (sweep_end) begin
            state <= S_DONE;
            idx   <= '0;
            // pass is registered together with entry to DONE so it is valid alongside done
            pass  <= (fail_count_nxt == '0);
          end else begin
            state <= S_DRIVE;
            idx   <= idx + N_IN'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: a randomized fault mask perturbs a reference combinational
// block; sweep results are predicted at accept time and checked by a done-driven monitor.
module tb_truth_table_sequencer;

  localparam int N_IN = 3;
  localparam int SETTLE = 2;
  localparam int NV = 1 << N_IN;
  localparam logic [NV-1:0] EXP_TT = 8'h31;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [N_IN-1:0] vec_out;
  logic            y_in;
  logic            busy, done, pass, fail_valid;
  logic [N_IN:0]   fail_count;
  logic [N_IN-1:0] first_fail_idx;

  truth_table_sequencer #(.N_IN(N_IN), .SETTLE(SETTLE), .EXPECTED(EXP_TT)) dut (
    .clk(clk), .reset(reset), .start(start), .vec_out(vec_out), .y_in(y_in),
    .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
    .fail_valid(fail_valid), .first_fail_idx(first_fail_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int cnt;
    int first;
    bit fv;
    bit ps;
  } exp_t;

  exp_t          sb[$];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            next_free = 0;
  int            cur_e = 0;
  int            cur_d = 0;
  bit            active = 1'b0;
  logic [NV-1:0] flip = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // reference block y = ~b & (~c | a), inputs {a,b,c} = vector bits MSB first
  function automatic logic model_y(int v);
    logic a, b, c;
    a = v[2]; b = v[1]; c = v[0];
    return ~b & (~c | a);
  endfunction

  always_comb y_in = model_y(int'(vec_out)) ^ flip[vec_out];

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t predict(int e, logic [NV-1:0] f);
    exp_t r;
    int last;
    logic [NV-1:0] tt;
    tt = EXP_TT;
    r = '{default: 0};
    last = NV - 1;
    for (int i = 0; i < NV; i++) begin
      if ((model_y(i) ^ f[i]) != tt[i]) begin
        if (!r.fv) begin
          r.first = i;
          r.fv = 1'b1;
        end
        r.cnt++;
`ifdef TT_STOP_ON_FAIL_EN
        last = i;
        break;
`endif
      end
    end
    r.d  = e + (last + 1) * (SETTLE + 1);
    r.ps = (r.cnt == 0);
    return r;
  endfunction

  // one clock edge with start driven; predicts acceptance from the bench's own idle model
  task automatic step(bit s, logic [NV-1:0] f);
    exp_t e;
    start = s;
    @(posedge clk);
    #1;
    if (s && cyc >= next_free) begin
      flip = f;
      e = predict(cyc, f);
      sb.push_back(e);
      cur_e = cyc;
      cur_d = e.d;
      active = 1'b1;
      next_free = e.d + 2;
      check("clr_count", int'(fail_count), 0);
      check("clr_valid", int'(fail_valid), 0);
      check("clr_pass", int'(pass), 0);
      check("accept_busy", int'(busy), 1);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    start = 1'b0;
    while (cyc < next_free && g < 400) begin
      step(1'b0, flip);
      g++;
    end
    checks++;
    if (cyc < next_free) begin
      errors++;
      $display("FAIL drain_timeout: cycle %0d still short of %0d", cyc, next_free);
    end
  endtask

  always @(negedge clk) begin
    int n;
    exp_t e;
    if (!reset) begin
      if (active) begin
        n = cyc - cur_e;
        if (n >= 0 && n < cur_d - cur_e) begin
          check("busy", int'(busy), 1);
          check("vec_out", int'(vec_out), n / (SETTLE + 1));
        end else if (n == cur_d - cur_e) begin
          check("busy_done", int'(busy), 0);
          check("vec_out_done", int'(vec_out), 0);
          active = 1'b0;
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.d);
          check("fail_count", int'(fail_count), e.cnt);
          check("fail_valid", int'(fail_valid), int'(e.fv));
          check("pass", int'(pass), int'(e.ps));
          if (e.fv) check("first_fail_idx", int'(first_fail_idx), e.first);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vec", int'(vec_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_count", int'(fail_count), 0);
    check("rst_valid", int'(fail_valid), 0);
    check("rst_first", int'(first_fail_idx), 0);
    reset = 1'b0;
    repeat (3) step(1'b0, '0);

    // correct block, stuck-at-0 output, single inverted vector 6
    step(1'b1, 8'h00); drain();
    step(1'b1, 8'h31); drain();
    step(1'b1, 8'h40); drain();
    step(1'b1, 8'h00); drain();

    // start held high: busy/DONE starts ignored, retrigger from IDLE
    repeat (40) step(1'b1, 8'h31);
    drain();

    // reset mid-sweep
    step(1'b1, 8'h31);
    repeat (10) step(1'b0, 8'h31);
    #1 reset = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_vec", int'(vec_out), 0);
    check("midrst_count", int'(fail_count), 0);
    check("midrst_valid", int'(fail_valid), 0);
    check("midrst_done", int'(done), 0);
    sb.delete();
    active = 1'b0;
    next_free = 0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (40) step(1'b0, '0);

    // random start pulses and fault masks
    repeat (400) begin
      logic [NV-1:0] f;
      f = ($urandom_range(0, 2) == 0) ? '0 : NV'($urandom);
      step($urandom_range(0, 3) == 0, f);
    end
    drain();
    repeat (4) step(1'b0, flip);
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
